// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
//   div_state_e   : controller states (IDLE, CALC, FIX, DONE)
//   div_spec_e    : special-case classification captured at accept
//   DIV_XLEN_DEFAULT : default operand/result width
//   div_cnt_width : iteration counter width for a given XLEN
package div_pkg;

    localparam int unsigned DIV_XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    typedef enum logic [1:0] {
        SPEC_NONE,
        SPEC_DIV0,
        SPEC_OVF,
        SPEC_ZERO
    } div_spec_e;

    function automatic int unsigned div_cnt_width(input int unsigned xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
// Ports:
//   rem_i, quo_i     : current partial remainder / quotient-shift register
//   divisor_mag_i    : divisor magnitude
//   rem_o, quo_o     : {rem,quo} shifted left by one with trial subtract applied
module div_step
    import div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_mag_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    // One extra bit: the shifted remainder can reach 2*divisor-1, which
    // does not fit in XLEN bits when the divisor magnitude is large.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_mag_i};
        if (!diff[XLEN]) begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle signed/unsigned integer divider (radix-2
// restoring, one quotient bit per cycle) with RISC-V M-extension results
// for divide-by-zero and signed overflow.
//
// Build option: DIV_FAST_SPECIAL_EN -- when defined, divide-by-zero, signed
// overflow and zero dividend skip the iteration and go straight to DONE.
// Results are identical either way; only latency differs.
//
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   start             : request level, sampled only in IDLE
//   flush             : synchronous abort, returns to IDLE, results untouched
//   dividend, divisor : operands, captured at accept
//   signed_dividend   : dividend is two's complement
//   signed_divisor    : divisor is two's complement
//   quotient          : result, held until the next result is written
//   remainder         : result, held until the next result is written
//   ready             : one-cycle result-valid pulse (registered)
//   busy              : high while in CALC or FIX
module iter_divider
    import div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            signed_dividend,
    input  logic            signed_divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            ready,
    output logic            busy
);

    localparam int unsigned     CNT_W    = div_cnt_width(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] orig_q, orig_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    div_spec_e       spec_q, spec_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;

    // Operand decode at the input side (used only when accepting).
    logic            dvd_neg, dvs_neg;
    logic [XLEN-1:0] dvd_mag, dvs_mag;
    div_spec_e       spec_in;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [2*XLEN-1:0] fix_spec_res;

    // {quotient, remainder} for a special case; SPEC_ZERO/SPEC_NONE give 0.
    function automatic logic [2*XLEN-1:0] special_result(input div_spec_e kind,
                                                         input logic [XLEN-1:0] a);
        case (kind)
            SPEC_DIV0: return {{XLEN{1'b1}}, a};
            SPEC_OVF:  return {a, {XLEN{1'b0}}};
            default:   return '0;
        endcase
    endfunction

    always_comb begin
        dvd_neg = signed_dividend & dividend[XLEN-1];
        dvs_neg = signed_divisor & divisor[XLEN-1];
        // Unsigned negation keeps the most negative value as 2^(XLEN-1).
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
        if (divisor == '0) begin
            spec_in = SPEC_DIV0;
        end else if (signed_dividend && signed_divisor &&
                     dividend == MIN_NEG && divisor == '1) begin
            spec_in = SPEC_OVF;
        end else if (dividend == '0) begin
            spec_in = SPEC_ZERO;
        end else begin
            spec_in = SPEC_NONE;
        end
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i         (rem_q),
        .quo_i         (quo_q),
        .divisor_mag_i (dvs_q),
        .rem_o         (step_rem),
        .quo_o         (step_quo)
    );

    // State register and all datapath/output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            orig_q      <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            spec_q      <= SPEC_NONE;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            orig_q      <= orig_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            spec_q      <= spec_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
`ifdef DIV_FAST_SPECIAL_EN
                        state_d = (spec_in != SPEC_NONE) ? DONE : CALC;
`else
                        state_d = CALC;
`endif
                    end
                end
                CALC:    if (cnt_q == '0) state_d = FIX;
                FIX:     state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and output logic.
    always_comb begin
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        orig_d       = orig_q;
        qneg_d       = qneg_q;
        rneg_d       = rneg_q;
        spec_d       = spec_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        fix_spec_res = special_result(spec_q, orig_q);

        // Registered from the next state so ready/busy have no input path
        // to the outputs and flush clears them on the following cycle.
        ready_d = (state_d == DONE);
        busy_d  = (state_d == CALC) || (state_d == FIX);

        if (!flush) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_d  = '0;
                        quo_d  = dvd_mag;
                        dvs_d  = dvs_mag;
                        orig_d = dividend;
                        qneg_d = dvd_neg ^ dvs_neg;
                        rneg_d = dvd_neg;
                        spec_d = spec_in;
                        cnt_d  = CNT_LAST;
`ifdef DIV_FAST_SPECIAL_EN
                        if (spec_in != SPEC_NONE) begin
                            {quotient_d, remainder_d} = special_result(spec_in, dividend);
                        end
`endif
                    end
                end
                CALC: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    // Special cases ran the full iteration for fixed latency;
                    // their iterated result is discarded here.
                    if (spec_q == SPEC_NONE) begin
                        quotient_d  = qneg_q ? -quo_q : quo_q;
                        remainder_d = rneg_q ? -rem_q : rem_q;
                    end else begin
                        {quotient_d, remainder_d} = fix_spec_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ready     = ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: self-checking bench for iter_divider (XLEN=64).
// Table of vectors plus hand-written abort, reset and back-to-back sequences;
// expected results are queued at launch and compared when ready pulses.
module tb_iter_divider;

    localparam int unsigned XLEN    = 64;
    localparam int          TIMEOUT = 300;
    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        signed_dividend;
    logic        signed_divisor;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        ready;
    logic        busy;

    iter_divider #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .flush           (flush),
        .dividend        (dividend),
        .divisor         (divisor),
        .signed_dividend (signed_dividend),
        .signed_divisor  (signed_divisor),
        .quotient        (quotient),
        .remainder       (remainder),
        .ready           (ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        sa;
        logic        sb;
        logic [63:0] q;
        logic [63:0] r;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_q = '0;
    logic [63:0] last_r = '0;

    // Reference: sign/zero-extend to 128 bits and use the language's
    // truncating division; that also yields the overflow result naturally.
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic sa, input logic sb);
        logic signed [127:0] xa, xb, xq, xr;
        if (b == 64'd0) return {64'hFFFF_FFFF_FFFF_FFFF, a};
        xa = sa ? {{64{a[63]}}, a} : {64'd0, a};
        xb = sb ? {{64{b[63]}}, b} : {64'd0, b};
        xq = xa / xb;
        xr = xa % xb;
        return {xq[63:0], xr[63:0]};
    endfunction

    function automatic int exp_latency(input vec_t v);
        bit special;
        special = (v.b == 64'd0) || (v.a == 64'd0) ||
                  (v.sa && v.sb && v.a == MIN_NEG && v.b == 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
        return special ? 1 : XLEN + 2;
`else
        return special ? XLEN + 2 : XLEN + 2;
`endif
    endfunction

    function automatic vec_t mk(input string n, input logic [63:0] a, input logic [63:0] b,
                                input logic sa, input logic sb,
                                input logic [63:0] q, input logic [63:0] r);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.sa = sa; v.sb = sb; v.q = q; v.r = r;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Drive operands with start high and queue the expected result.
    task automatic drive_op(input vec_t v);
        exp_t e;
        dividend        = v.a;
        divisor         = v.b;
        signed_dividend = v.sa;
        signed_divisor  = v.sb;
        start           = 1'b1;
        e.name = v.name; e.q = v.q; e.r = v.r; e.lat = exp_latency(v);
        sb_q.push_back(e);
    endtask

    // Called #1 after the accepting edge; waits for ready and compares.
    task automatic collect();
        int   lat;
        int   busy_n;
        exp_t e;
        lat    = 1;
        busy_n = 0;
        while (!ready && lat < TIMEOUT) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: ready with empty queue");
            return;
        end
        e = sb_q.pop_front();
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ready after %0d edges, expected %0d", e.name, lat, e.lat);
            return;
        end
        check({e.name, "_quotient"}, quotient, e.q);
        check({e.name, "_remainder"}, remainder, e.r);
        check({e.name, "_latency"}, 64'(lat), 64'(e.lat));
        check({e.name, "_busy_cycles"}, 64'(busy_n), 64'(e.lat - 1));
        last_q = e.q;
        last_r = e.r;
        @(posedge clk); #1;
        check({e.name, "_ready_pulse"}, {63'd0, ready}, 64'd0);
    endtask

    task automatic run_op(input vec_t v);
        drive_op(v);
        @(posedge clk); #1;
        start = 1'b0;
        collect();
    endtask

    initial begin
        vec_t        v;
        int          seen;
        logic [63:0] a, b;
        logic        sa, sb;
        logic [127:0] m;

        reset = 1'b0; start = 1'b0; flush = 1'b0;
        dividend = '0; divisor = '0; signed_dividend = 1'b0; signed_divisor = 1'b0;

        tbl.push_back(mk("u_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2));
        tbl.push_back(mk("s_m100_7", -64'sd100, 64'd7, 1'b1, 1'b1,
                         64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE));
        tbl.push_back(mk("s_100_m7", 64'd100, -64'sd7, 1'b1, 1'b1,
                         64'hFFFF_FFFF_FFFF_FFF2, 64'd2));
        tbl.push_back(mk("s_div0", 64'h1234, 64'd0, 1'b1, 1'b1,
                         64'hFFFF_FFFF_FFFF_FFFF, 64'h1234));
        tbl.push_back(mk("u_div0", 64'h1234, 64'd0, 1'b0, 1'b0,
                         64'hFFFF_FFFF_FFFF_FFFF, 64'h1234));
        tbl.push_back(mk("s_ovf", MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, MIN_NEG, 64'd0));
        tbl.push_back(mk("u_ovf", MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0, MIN_NEG));
        tbl.push_back(mk("u_zero_dvd", 64'd0, 64'd5, 1'b0, 1'b0, 64'd0, 64'd0));
        tbl.push_back(mk("mix_m1_2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0,
                         64'd0, 64'hFFFF_FFFF_FFFF_FFFF));
        tbl.push_back(mk("mix_7_m1", 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
                         64'hFFFF_FFFF_FFFF_FFF9, 64'd0));
        tbl.push_back(mk("u_max_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                         64'hFFFF_FFFF_FFFF_FFFF, 64'd0));
        for (int i = 0; i < 6; i++) begin
            a  = {$urandom, $urandom};
            b  = {32'd0, $urandom} >> $urandom_range(0, 28);
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            if (i[0]) b = -b;
            m = model(a, b, sa, sb);
            tbl.push_back(mk($sformatf("rand%0d", i), a, b, sa, sb, m[127:64], m[63:0]));
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_quotient", quotient, 64'd0);
        check("rst_remainder", remainder, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i]);
        end

        // Abort at CALC cycle 20, then immediate restart.
        dividend = 64'd1000; divisor = 64'd3;
        signed_dividend = 1'b0; signed_divisor = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_ready", {63'd0, ready}, 64'd0);
        check("abort_quotient_held", quotient, last_q);
        check("abort_remainder_held", remainder, last_r);
        run_op(mk("restart_9_3", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0));

        // Reset mid-CALC.
        dividend = 64'hDEAD_BEEF; divisor = 64'h13;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_quotient", quotient, 64'd0);
        check("midrst_remainder", remainder, 64'd0);
        check("midrst_ready", {63'd0, ready}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (ready || busy) seen++;
        end
        check("midrst_no_activity", 64'(seen), 64'd0);

        // Back-to-back: start held through DONE re-executes the same operation.
        v = mk("b2b_first", 64'd1000, 64'd3, 1'b0, 1'b0, 64'd333, 64'd1);
        drive_op(v);
        @(posedge clk); #1;
        collect();
        v.name = "b2b_second";
        drive_op(v);
        @(posedge clk); #1;
        start = 1'b0;
        collect();
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
